// File: rtl/instruction_fetch.sv
// MIPS fetch stage: owns the PC and picks the next one (sequential, branch or jump).
// It drives the instruction-memory read and carries the IF/ID side-band values. Supports halt and debug single-step.
module instruction_fetch #(
  parameter int PC_WIDTH   = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_branch_taken,
  input  logic [PC_WIDTH-1:0]   i_branch_target,
  input  logic                  i_jump,
  input  logic [PC_WIDTH-1:0]   i_jump_target,
  input  logic                  i_halt,
  output logic [ADDR_WIDTH-1:0] o_mem_address,
  output logic                  o_mem_read,
  output logic [PC_WIDTH-1:0]   o_pc,
  output logic [PC_WIDTH-1:0]   o_ifid_pc_plus4,
  output logic                  o_ifid_valid,
  output logic                  o_halted,
  output logic [31:0]           o_cycle_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_reg, state_next;
  logic                step_q_reg;
  logic [PC_WIDTH-1:0] pc_reg, pc_next;
  logic [PC_WIDTH-1:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
  logic                ifid_valid_reg, ifid_valid_next;
  logic [31:0]         cycle_count_reg, cycle_count_next;

  logic                step_ok, go, redirect, advance, fire;
  logic [PC_WIDTH-1:0] pc_plus4, target_sel;

  assign pc_plus4 = pc_reg + PC_WIDTH'(4);
  assign step_ok  = !i_step_mode || (i_step && !step_q_reg);
  // Reset gates go so no read strobe escapes during the reset cycle.
  assign go       = !i_reset && (state_reg == RUN) && i_valid && !i_halt && step_ok;
  assign redirect = go && (i_jump || i_branch_taken);
  assign advance  = go && !i_stall && !redirect;
  assign fire     = redirect || advance;

  assign target_sel = i_jump ? i_jump_target : i_branch_target;

  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    ifid_pc_plus4_next = ifid_pc_plus4_reg;
    ifid_valid_next    = ifid_valid_reg;
    cycle_count_next   = cycle_count_reg;

    case (state_reg)
      RUN:     if (i_halt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase

    if (redirect) begin
      pc_next = target_sel & ~PC_WIDTH'(3);
    end else if (advance) begin
      pc_next = pc_plus4;
    end

    if (fire) begin
      ifid_pc_plus4_next = pc_plus4;
      ifid_valid_next    = advance;
      cycle_count_next   = cycle_count_reg + 32'd1;
    end else if (state_reg != RUN) begin
      ifid_valid_next = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg         <= RUN;
      step_q_reg        <= 1'b0;
      pc_reg            <= '0;
      ifid_pc_plus4_reg <= '0;
      ifid_valid_reg    <= 1'b0;
      cycle_count_reg   <= '0;
    end else begin
      state_reg         <= state_next;
      step_q_reg        <= i_step;
      pc_reg            <= pc_next;
      ifid_pc_plus4_reg <= ifid_pc_plus4_next;
      ifid_valid_reg    <= ifid_valid_next;
      cycle_count_reg   <= cycle_count_next;
    end
  end

  assign o_mem_address   = pc_reg[ADDR_WIDTH+1:2];
  assign o_mem_read      = fire;
  assign o_pc            = pc_reg;
  assign o_ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign o_ifid_valid    = ifid_valid_reg;
  assign o_halted        = (state_reg == HALTED);
  assign o_cycle_count   = cycle_count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: expectations are queued with each stimulus step.
// They are popped and checked once the DUT has responded.
module tb_instruction_fetch;

  localparam int PC_WIDTH   = 32;
  localparam int ADDR_WIDTH = 7;

  logic                  i_clk = 1'b0;
  logic                  i_reset, i_valid, i_step_mode, i_step, i_stall;
  logic                  i_branch_taken, i_jump, i_halt;
  logic [PC_WIDTH-1:0]   i_branch_target, i_jump_target;
  logic [ADDR_WIDTH-1:0] o_mem_address;
  logic                  o_mem_read, o_ifid_valid, o_halted;
  logic [PC_WIDTH-1:0]   o_pc, o_ifid_pc_plus4;
  logic [31:0]           o_cycle_count;

  instruction_fetch #(.PC_WIDTH(PC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_step_mode(i_step_mode),
    .i_step(i_step), .i_stall(i_stall), .i_branch_taken(i_branch_taken),
    .i_branch_target(i_branch_target), .i_jump(i_jump), .i_jump_target(i_jump_target),
    .i_halt(i_halt), .o_mem_address(o_mem_address), .o_mem_read(o_mem_read),
    .o_pc(o_pc), .o_ifid_pc_plus4(o_ifid_pc_plus4), .o_ifid_valid(o_ifid_valid),
    .o_halted(o_halted), .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  localparam int S_PC = 0, S_ADDR = 1, S_RD = 2, S_PP4 = 3, S_VLD = 4, S_HLT = 5, S_CC = 6;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_PC:    return o_pc;
      S_ADDR:  return 32'(o_mem_address);
      S_RD:    return 32'(o_mem_read);
      S_PP4:   return o_ifid_pc_plus4;
      S_VLD:   return 32'(o_ifid_valid);
      S_HLT:   return 32'(o_halted);
      default: return o_cycle_count;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      n_cmp++;
      assert (obs === e.exp)
      else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
      end
      $display("check %-14s observed %0h expected %0h", e.tag, obs, e.exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge i_clk);
    #1;
    drain();
  endtask

  task automatic now_check();
    #1;
    drain();
  endtask

  task automatic exp_core(input string tag, input logic [31:0] pc, input logic [31:0] pp4,
                          input logic vld, input logic [31:0] cc);
    push({tag, ".pc"}, S_PC, pc);
    push({tag, ".pp4"}, S_PP4, pp4);
    push({tag, ".vld"}, S_VLD, 32'(vld));
    push({tag, ".cc"}, S_CC, cc);
  endtask

  initial begin
    i_reset = 1'b1; i_valid = 1'b0; i_step_mode = 1'b0; i_step = 1'b0; i_stall = 1'b0;
    i_branch_taken = 1'b0; i_jump = 1'b0; i_halt = 1'b0;
    i_branch_target = '0; i_jump_target = '0;
    tick();
    i_valid = 1'b1;
    push("rst_rd", S_RD, 0); now_check();
    tick();
    exp_core("reset", 0, 0, 0, 0);
    push("reset.addr", S_ADDR, 0); push("reset.hlt", S_HLT, 0);
    now_check();
    i_reset = 1'b0;

    // Sequential fetch
    push("seq_rd", S_RD, 1); now_check();
    exp_core("seq1", 4, 4, 1, 1); push("seq1.addr", S_ADDR, 1); tick();
    exp_core("seq2", 8, 8, 1, 2); push("seq2.addr", S_ADDR, 2); tick();

    // Load-use stall holds PC and IF/ID
    i_stall = 1'b1;
    push("stall_rd", S_RD, 0); now_check();
    exp_core("stall1", 8, 8, 1, 2); tick();
    exp_core("stall2", 8, 8, 1, 2); tick();
    i_stall = 1'b0;
    exp_core("resume", 12, 12, 1, 3); tick();

    // Branch with misaligned target bits
    i_branch_taken = 1'b1; i_branch_target = 32'h43;
    push("br_rd", S_RD, 1); now_check();
    exp_core("branch", 32'h40, 16, 0, 4); tick();
    i_branch_taken = 1'b0;
    exp_core("after_br", 32'h44, 32'h44, 1, 5); tick();

    // Jump wins over branch
    i_jump = 1'b1; i_jump_target = 32'h80; i_branch_taken = 1'b1; i_branch_target = 32'h40;
    exp_core("jmp_br", 32'h80, 32'h48, 0, 6); tick();
    i_jump = 1'b0;

    // Redirect wins over stall
    i_stall = 1'b1; i_branch_target = 32'h10;
    exp_core("br_stall", 32'h10, 32'h84, 0, 7); tick();
    i_branch_taken = 1'b0;
    exp_core("stall_hold", 32'h10, 32'h84, 0, 7); tick();
    i_stall = 1'b0;
    exp_core("run14", 32'h14, 32'h14, 1, 8); tick();

    // Halt at PC=20 is sticky and blocks redirects
    i_halt = 1'b1;
    push("halt_rd", S_RD, 0); now_check();
    exp_core("halt", 32'h14, 32'h14, 1, 8); push("halt.hlt", S_HLT, 1); tick();
    i_halt = 1'b0; i_branch_taken = 1'b1; i_branch_target = 32'h40;
    push("halted_rd", S_RD, 0); now_check();
    exp_core("halted", 32'h14, 32'h14, 0, 8); push("halted.hlt", S_HLT, 1); tick();
    i_branch_taken = 1'b0;
    i_reset = 1'b1;
    exp_core("unhalt", 0, 0, 0, 0); push("unhalt.hlt", S_HLT, 0); tick();
    i_reset = 1'b0;

    // Step mode: held step gives one fire, then single pulses
    i_step_mode = 1'b1;
    exp_core("no_step", 0, 0, 0, 0); tick();
    i_step = 1'b1;
    exp_core("hold1", 4, 4, 1, 1); tick();
    for (int k = 0; k < 4; k++) begin
      push("hold_rd", S_RD, 0); push("hold_pc", S_PC, 4); push("hold_cc", S_CC, 1); tick();
    end
    i_step = 1'b0; push("rel_pc", S_PC, 4); tick();
    i_step = 1'b1; exp_core("pulse1", 8, 8, 1, 2); tick();
    i_step = 1'b0; push("rel_pc", S_PC, 8); tick();
    i_step = 1'b1; exp_core("pulse2", 12, 12, 1, 3); tick();
    i_step = 1'b0; tick();
    // Step edge during a stall is consumed without advancing
    i_step = 1'b1; i_stall = 1'b1;
    exp_core("step_stall", 12, 12, 1, 3); tick();
    i_step = 1'b1; i_stall = 1'b0;
    push("stale_step", S_PC, 12); tick();
    i_step = 1'b0; i_step_mode = 1'b0;

    // PC wraps modulo 2^32 and word address aliases
    i_jump = 1'b1; i_jump_target = 32'hFFFF_FFFC;
    exp_core("jmp_top", 32'hFFFF_FFFC, 16, 0, 4); push("top.addr", S_ADDR, 32'h7F); tick();
    i_jump = 1'b0;
    exp_core("pc_wrap", 0, 0, 1, 5); push("wrap.addr", S_ADDR, 0); tick();
    i_jump = 1'b1; i_jump_target = 32'h204;
    push("alias.pc", S_PC, 32'h204); push("alias.addr", S_ADDR, 1); tick();

    // Reset mid-run discards a pending jump
    i_jump_target = 32'h24;
    exp_core("to24", 32'h24, 32'h208, 0, 7); tick();
    i_jump_target = 32'h80; i_reset = 1'b1;
    push("rst_jmp_rd", S_RD, 0); now_check();
    exp_core("rst_mid", 0, 0, 0, 0); push("rst_mid.hlt", S_HLT, 0); tick();
    i_reset = 1'b0; i_jump = 1'b0; i_valid = 1'b0;
    push("idle_pc", S_PC, 0); push("idle_rd", S_RD, 0); tick();
    i_valid = 1'b1;
    exp_core("restart", 4, 4, 1, 1); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the pipelined MIPS datapath. It owns the program counter, computes the next PC (sequential, branch, jump), and drives the word address and read strobe of the instruction memory. It also carries the IF/ID side-band values (PC+4, valid) aligned with the instruction word that memory returns one cycle later. It stops permanently when the memory flags a HALT opcode, and supports single-step operation under debug-unit control.

## Interface
- PC_WIDTH, 32, byte-address width of the program counter.
- ADDR_WIDTH, 7, instruction-memory word-address width (128 words).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- i_valid  in  1  debug unit enables execution; when 0 nothing advances.
- i_step_mode  in  1  1 = advance only on a rising edge of i_step.
- i_step  in  1  step request from the debug unit; level signal, edge-detected internally.
- i_stall  in  1  hazard unit load-use stall.
- i_branch_taken  in  1  branch resolved taken.
- i_branch_target  in  PC_WIDTH  branch byte address.
- i_jump  in  1  jump (J/JAL/JR/JALR).
- i_jump_target  in  PC_WIDTH  jump byte address.
- i_halt  in  1  HALT detected by instruction memory (updated on falling edge).
- o_mem_address  out  ADDR_WIDTH  word address = o_pc[ADDR_WIDTH+1:2]; combinational from the PC register.
- o_mem_read  out  1  memory read strobe; combinational, equals fire (defined below).
- o_pc  out  PC_WIDTH  current PC.
- o_ifid_pc_plus4  out  PC_WIDTH  PC+4 of the instruction presented by memory this cycle.
- o_ifid_valid  out  1  instruction presented by memory is live (0 = bubble or flushed).
- o_halted  out  1  sticky halt flag.
- o_cycle_count  out  32  count of cycles with fire=1; used by the debug unit.

## Operation
- States: RUN, HALTED. Reset sets RUN. RUN→HALTED when i_halt=1 at a rising edge. HALTED is left only by reset.
- step_ok = !i_step_mode || (i_step && !step_q). step_q is i_step registered each cycle (reset 0).
- go = state==RUN && i_valid && !i_halt && step_ok.
- redirect = go && (i_jump || i_branch_taken). Redirect ignores i_stall.
- advance = go && !i_stall && !redirect.
- fire = redirect || advance.
- Next PC priority:
  - i_jump → i_jump_target.
  - else i_branch_taken → i_branch_target.
  - else advance → o_pc+4. Addition is modulo 2^PC_WIDTH.
  - else hold.
- Target bits [1:0] are ignored (forced to 00 on load).
- At each edge with fire=1:
  - o_ifid_pc_plus4 ← o_pc+4.
  - o_ifid_valid ← advance. A redirect emits a bubble; the instruction read that cycle is the wrong-path one.
- At edges with fire=0, o_ifid_pc_plus4 holds and o_ifid_valid ← 0 only if state≠RUN. Otherwise it holds. Stall keeps IF/ID intact, since memory output is frozen while o_mem_read=0.
- o_halted = (state==HALTED).
- o_cycle_count increments on fire and wraps at 2^32.

## Timing
- Reset values:
  - o_pc=0, o_mem_address=0.
  - o_ifid_pc_plus4=0, o_ifid_valid=0.
  - o_halted=0, o_cycle_count=0.
  - step_q=0, state=RUN.
- o_mem_read is 0 during the reset cycle.
- Fetch latency is 1 cycle. Address A, sampled by memory at edge k, appears on memory data in cycle k+1. o_ifid_pc_plus4 and o_ifid_valid update at the same edge k, so they align with that data.
- Address wrap: PC beyond 4·2^ADDR_WIDTH aliases through o_mem_address truncation. No error is raised.
- Simultaneous events:
  - i_reset beats everything.
  - i_halt beats redirect, stall and step.
  - jump beats branch.
  - redirect beats stall.
- Step mode: one fire per i_step rising edge. A step held high for N cycles gives exactly one fire. If the step edge arrives while i_stall=1 and no redirect is pending, it is consumed with no advance.
- Reset mid-run or in HALTED: the PC returns to 0 on the next edge, and fetch resumes from address 0 on the following edge if i_valid=1.

## Test plan
- Sequential run: i_valid=1, no hazards, for 4 cycles.
  - o_pc: 0,4,8,12,16.
  - o_mem_address: 0,1,2,3,4.
  - o_ifid_pc_plus4 lags one cycle (4,8,12,16); o_ifid_valid=1 from cycle 2; o_cycle_count=4.
- Stall: assert i_stall at PC=8 for 2 cycles.
  - o_pc holds 8 and o_mem_read=0 for 2 cycles.
  - o_ifid_pc_plus4 holds 8 and o_ifid_valid holds 1.
  - PC resumes to 12.
- Redirect:
  - Branch alone: i_branch_taken=1, target 0x40, at PC=12 → o_pc=0x40 next cycle; o_ifid_valid=0 for one cycle; o_ifid_pc_plus4=16.
  - Jump and branch together (jump 0x80, branch 0x40) → o_pc=0x80.
  - Redirect with i_stall=1 → redirect still taken.
- Halt: raise i_halt at PC=20.
  - o_halted=1 next edge; o_pc frozen at 20 and o_mem_read=0 thereafter.
  - Subsequent i_branch_taken is ignored.
  - i_reset → o_pc=0, o_halted=0.
- Step mode: i_step_mode=1, i_step held high for 5 cycles, then pulsed twice.
  - o_pc advances 0→4 on the hold, then 8, 12.
  - o_cycle_count=3.
- Reset mid-operation: assert i_reset at PC=0x24 with a pending jump.
  - All outputs take their reset values; the jump is discarded.
